uart_rx_deser: RTL

UART receive deserializer, the stage directly upstream of the UART echo/consumer logic in the 200 MHz domain. It synchronises the raw rx pin, detects and validates start bits, and samples 8N1 frames at mid-bit. Each received byte is presented on a valid/ready output with frame-error and overrun reporting.

---
 rtl/uart_rx_deser_if.sv | 25 ++
 rtl/uart_rx_deser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser_if.sv
// Byte-level output bus of the UART receive deserializer: valid/ready data
// plus the one-cycle frame-error and overrun status pulses.
interface uart_rx_deser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: synchronises the rx pin, validates start bits,
// samples data at mid-bit and presents each byte on a valid/ready bus.
module uart_rx_deser #(
  parameter int CLK_FREQ = 200000000,
  parameter int BAUD     = 115200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uart_rx,
  uart_rx_deser_if.master rx_bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx_deser: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic             meta_r;
  logic             rxs_r;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_s;
  logic             byte_done_s;
  logic             stop_err_s;
  logic             handshake_s;

  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             overrun_r;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b1;
      rxs_r  <= 1'b1;
    end else begin
      meta_r <= uart_rx;
      rxs_r  <= meta_r;
    end
  end

  // Receiver state, baud counter, bit index and assembly register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
    end
  end

  // Next-state logic; the half-bit START wait puts later samples at mid-bit.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    byte_done_s = 1'b0;
    stop_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_s = ST_START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = CNT_ZERO;
          if (rxs_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s              = CNT_ZERO;
          shift_s[bit_idx_r] = rxs_r;
          bit_idx_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rxs_r) begin
            byte_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            stop_err_s = 1'b1;
            state_s    = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_BREAK: begin
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign handshake_s = rx_valid_r && rx_bus.rx_ready;

  // Output holding register; a completing byte may replace one being consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_err_s;
      overrun_r   <= 1'b0;
      if (byte_done_s) begin
        if (!rx_valid_r || handshake_s) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (handshake_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_bus.rx_data   = rx_data_r;
  assign rx_bus.rx_valid  = rx_valid_r;
  assign rx_bus.frame_err = frame_err_r;
  assign rx_bus.overrun   = overrun_r;

endmodule
